// File: rtl/timer_pkg.sv
// Shared definitions for the microwave timer entry stage: keypad geometry,
// debounce state encoding and the keypad-to-code encoder.
// Build option: MULTI_KEY_REJECT_EN changes how multi-key samples are treated
// by the debounce block. The encoder output itself is the same in both builds.
package timer_pkg;

   localparam int KEYS  = 10;
   localparam int BCD_W = 4;

   typedef enum logic [1:0] {
      ST_ARMED     = 2'd0,
      ST_HELD      = 2'd1,
      ST_RELEASING = 2'd2
   } deb_state_e;

   // valid: exactly one key down; multi: more than one key down.
   // code is always the highest pressed key index (0 when idle).
   typedef struct packed {
      logic [BCD_W-1:0] code;
      logic             valid;
      logic             multi;
   } key_code_t;

   function automatic key_code_t encode_keypad(input logic [KEYS-1:0] keypad);
      key_code_t   r;
      int unsigned ones;
      r.code  = '0;
      r.valid = 1'b0;
      r.multi = 1'b0;
      ones    = 0;
      // Ascending scan so the highest pressed index wins.
      for (int k = 0; k < KEYS; k++) begin
         if (keypad[k]) begin
            r.code = BCD_W'(k);
            ones   = ones + 1;
         end
      end
      r.valid = (ones == 1);
      r.multi = (ones > 1);
      return r;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Keypad encoder plus press/release debounce FSM.
// hit flags that the current sample completes a stable run of DEBOUNCE_CYCLES
// identical usable codes; it is only meaningful while state is ST_ARMED, so
// the consumer qualifies it with the exported state.
// Build option: MULTI_KEY_REJECT_EN makes multi-key samples unusable for a
// press (they still count as "not idle" for release detection).
module keypad_debounce
   import timer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable_n,
   input  logic [KEYS-1:0]  keypad,
   output logic [BCD_W-1:0] code,
   output logic             hit,
   output deb_state_e       state
);

   localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);

   deb_state_e       state_next;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic [CNT_W-1:0] count_inc;
   logic [CNT_W-1:0] run_next;
   logic [BCD_W-1:0] last_code;
   logic [BCD_W-1:0] last_code_next;
   key_code_t        kc;
   logic             idle;
   logic             usable;
   logic             same;

   assign kc   = encode_keypad(keypad);
   assign idle = !(kc.valid || kc.multi);
   assign code = kc.code;

`ifdef MULTI_KEY_REJECT_EN
   assign usable = kc.valid;
`else
   assign usable = kc.valid || kc.multi;
`endif

   // A run continues only if a run is in progress and the code is unchanged.
   assign count_inc = count + 1'b1;
   assign same      = (count != '0) && (kc.code == last_code);
   assign run_next  = same ? count_inc : CNT_W'(1);
   assign hit       = !enable_n && usable && (run_next == CNT_TARGET);

   // State, run/idle counter and the code of the current run.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_ARMED;
         count     <= '0;
         last_code <= '0;
      end else begin
         state     <= state_next;
         count     <= count_next;
         last_code <= last_code_next;
      end
   end

   // Next-state logic; count means "identical samples" in ARMED and
   // "consecutive idle samples" in RELEASING.
   always_comb begin
      state_next     = state;
      count_next     = count;
      last_code_next = last_code;
      if (enable_n) begin
         state_next = ST_ARMED;
         count_next = '0;
      end else begin
         case (state)
            ST_ARMED: begin
               if (!usable) begin
                  count_next = '0;
               end else if (hit) begin
                  state_next = ST_HELD;
                  count_next = '0;
               end else begin
                  count_next     = run_next;
                  last_code_next = kc.code;
               end
            end
            ST_HELD: begin
               if (idle) begin
                  // The first idle sample already counts toward release.
                  if (DEBOUNCE_CYCLES == 1) begin
                     state_next = ST_ARMED;
                     count_next = '0;
                  end else begin
                     state_next = ST_RELEASING;
                     count_next = CNT_W'(1);
                  end
               end
            end
            ST_RELEASING: begin
               if (!idle) begin
                  state_next = ST_HELD;
                  count_next = '0;
               end else if (count_inc == CNT_TARGET) begin
                  state_next = ST_ARMED;
                  count_next = '0;
               end else begin
                  count_next = count_inc;
               end
            end
            default: begin
               state_next = ST_ARMED;
               count_next = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/timer_entry_control.sv
// Keypad-to-timer entry stage: debounced digit entry into an N-digit BCD
// buffer (newest digit in the low nibble) plus the 1 Hz timebase divider.
// Build option: MULTI_KEY_REJECT_EN (multi-key samples are never accepted;
// otherwise the highest pressed key is used). Port list is the same either way.
module timer_entry_control
   import timer_pkg::*;
#(
   parameter int N_DIGITS        = 4,
   parameter int DEBOUNCE_CYCLES = 3,
   parameter int DIV_RATIO       = 100
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              enable_n,
   input  logic [KEYS-1:0]                   keypad,
   output logic [BCD_W-1:0]                  D,
   output logic [BCD_W*N_DIGITS-1:0]         digits,
   output logic [$clog2(N_DIGITS+1)-1:0]     digit_count,
   output logic                              load_n,
   output logic                              pgt_1Hz
);

   localparam int DW    = BCD_W * N_DIGITS;
   localparam int CW    = $clog2(N_DIGITS + 1);
   localparam int DIV_W = $clog2(DIV_RATIO);

   logic [BCD_W-1:0] deb_code;
   logic             deb_hit;
   deb_state_e       deb_state;
   logic             accept;
   logic [DIV_W-1:0] div_count;
   logic [DIV_W-1:0] div_next;

   keypad_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clock    (clock),
      .reset    (reset),
      .enable_n (enable_n),
      .keypad   (keypad),
      .code     (deb_code),
      .hit      (deb_hit),
      .state    (deb_state)
   );

   // A digit is taken only on the completing sample of a run while armed.
   assign accept = deb_hit && (deb_state == ST_ARMED);

   // Entry buffer: shift newest digit in at the bottom, oldest falls off the top.
   always_ff @(posedge clock) begin
      if (reset) begin
         D           <= '0;
         digits      <= '0;
         digit_count <= '0;
         load_n      <= 1'b1;
      end else begin
         load_n <= !accept;
         if (accept) begin
            D      <= deb_code;
            digits <= DW'({digits, deb_code});
            if (digit_count != CW'(N_DIGITS)) begin
               digit_count <= digit_count + 1'b1;
            end
         end
      end
   end

   assign div_next = (div_count == DIV_W'(DIV_RATIO - 1)) ? '0 : div_count + 1'b1;

   // Free-running divider; pgt_1Hz is high for the upper half of each period
   // and is registered in step with the counter it is derived from.
   always_ff @(posedge clock) begin
      if (reset) begin
         div_count <= '0;
         pgt_1Hz   <= 1'b0;
      end else begin
         div_count <= div_next;
         pgt_1Hz   <= (div_next >= DIV_W'(DIV_RATIO / 2));
      end
   end

endmodule

// File: tb/tb_timer_entry_control.sv
// Bench for timer_entry_control with N_DIGITS=4, DEBOUNCE_CYCLES=3, DIV_RATIO=100.
module tb_timer_entry_control;

   localparam int N_DIGITS = 4;
   localparam int DC       = 3;
   localparam int DIV      = 100;

   // ---------------- clock / reset ----------------
   logic        clock    = 1'b0;
   logic        reset    = 1'b1;
   logic        enable_n = 1'b0;
   logic [9:0]  keypad   = '0;
   logic [3:0]  D;
   logic [15:0] digits;
   logic [2:0]  digit_count;
   logic        load_n;
   logic        pgt_1Hz;

   always #5 clock = ~clock;

   timer_entry_control #(
      .N_DIGITS        (N_DIGITS),
      .DEBOUNCE_CYCLES (DC),
      .DIV_RATIO       (DIV)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable_n    (enable_n),
      .keypad      (keypad),
      .D           (D),
      .digits      (digits),
      .digit_count (digit_count),
      .load_n      (load_n),
      .pgt_1Hz     (pgt_1Hz)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Armed: count identical usable samples; after a take, wait for DC idle samples.
   bit         m_live = 1'b0;
   bit         m_armed;
   int         m_run, m_last, m_idle_run, m_cnt, m_div, cyc;
   logic [3:0] m_D;
   logic [3:0] m_dig [4];
   logic       m_load_n;

   function automatic int model_code(input logic [9:0] k);
      int ones = 0;
      int idx  = -1;
      for (int i = 0; i < 10; i++) begin
         if (k[i]) begin
            ones++;
            idx = i;
         end
      end
`ifdef MULTI_KEY_REJECT_EN
      return (ones == 1) ? idx : -1;
`else
      return (ones > 0) ? idx : -1;
`endif
   endfunction

   always @(posedge clock) begin
      int c;
      if (reset) begin
         m_live = 1'b1; m_armed = 1'b1; m_run = 0; m_last = 0; m_idle_run = 0;
         m_cnt = 0; m_div = 0; cyc = 0; m_D = '0; m_load_n = 1'b1;
         for (int i = 0; i < 4; i++) m_dig[i] = '0;
      end else if (m_live) begin
         cyc++;
         m_div    = (m_div + 1) % DIV;
         m_load_n = 1'b1;
         if (enable_n) begin
            m_armed = 1'b1;
            m_run   = 0;
         end else if (m_armed) begin
            c = model_code(keypad);
            if (c < 0) m_run = 0;
            else if (m_run > 0 && c == m_last) m_run++;
            else begin
               m_run  = 1;
               m_last = c;
            end
            if (m_run == DC) begin
               m_D = 4'(c);
               for (int i = 3; i > 0; i--) m_dig[i] = m_dig[i-1];
               m_dig[0] = 4'(c);
               if (m_cnt < N_DIGITS) m_cnt++;
               m_load_n   = 1'b0;
               m_armed    = 1'b0;
               m_run      = 0;
               m_idle_run = 0;
            end
         end else begin
            if (keypad == '0) m_idle_run++;
            else m_idle_run = 0;
            if (m_idle_run == DC) begin
               m_armed = 1'b1;
               m_run   = 0;
            end
         end
      end
   end

   // ---------------- compare process + scoreboard ----------------
   logic [3:0] exp_q[$];
   int         rise_q[$];
   int         pulses = 0;
   int         last_pulse_cyc = 0;
   logic       prev_pgt = 1'b0;

   always @(negedge clock) begin
      if (m_live) begin
         check("model_D", 32'(D), 32'(m_D));
         check("model_digits", 32'(digits), 32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
         check("model_count", 32'(digit_count), 32'(m_cnt));
         check("model_load_n", 32'(load_n), 32'(m_load_n));
         check("model_pgt", 32'(pgt_1Hz), 32'(m_div >= DIV / 2));
         if (pgt_1Hz === 1'b1 && prev_pgt === 1'b0) rise_q.push_back(cyc);
         prev_pgt = pgt_1Hz;
         if (load_n === 1'b0) begin
            pulses++;
            last_pulse_cyc = cyc;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_load actual_D=%0h required=no_pulse", D);
            end else begin
               check("load_digit", 32'(D), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic press(input int k, input int hold, input int rel);
      keypad    = '0;
      keypad[k] = 1'b1;
      step(hold);
      keypad = '0;
      step(rel);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int p0;
      int start;
      int rise_exp [3];
      rise_exp[0] = 50; rise_exp[1] = 150; rise_exp[2] = 250;

      reset = 1'b1; enable_n = 1'b0; keypad = '0;
      step(2);
      check("rst_D", 32'(D), 32'h0);
      check("rst_digits", 32'(digits), 32'h0);
      check("rst_count", 32'(digit_count), 32'h0);
      check("rst_load_n", 32'(load_n), 32'h1);
      check("rst_pgt", 32'(pgt_1Hz), 32'h0);
      reset = 1'b0;

      // Idle divider run
      step(300);
      check("rise_count", 32'(rise_q.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         check("rise_cycle", (i < rise_q.size()) ? 32'(rise_q[i]) : 32'hffff_ffff, 32'(rise_exp[i]));
      check("idle_pulses", 32'(pulses), 32'd0);

      // Digits 4, 7, 2
      p0 = pulses;
      exp_q.push_back(4'd4); exp_q.push_back(4'd7); exp_q.push_back(4'd2);
      press(4, 10, 10); press(7, 10, 10); press(2, 10, 10);
      check("s2_pulses", 32'(pulses - p0), 32'd3);
      check("s2_D", 32'(D), 32'h2);
      check("s2_digits", 32'(digits), 32'h0472);
      check("s2_count", 32'(digit_count), 32'd3);

      // Short bounce of key 5, then a long hold
      p0 = pulses;
      press(5, 2, 10);
      exp_q.push_back(4'd5);
      keypad = '0; keypad[5] = 1'b1;
      start = cyc;
      step(20);
      check("s3_latency", 32'(last_pulse_cyc - (start + 1)), 32'd2);
      keypad = '0;
      step(10);
      check("s3_pulses", 32'(pulses - p0), 32'd1);
      check("s3_digits", 32'(digits), 32'h4725);
      check("s3_count", 32'(digit_count), 32'd4);

      // Overflow: 1..5
      p0 = pulses;
      for (int k = 1; k <= 5; k++) begin
         exp_q.push_back(4'(k));
         press(k, 10, 10);
      end
      check("s4_pulses", 32'(pulses - p0), 32'd5);
      check("s4_digits", 32'(digits), 32'h2345);
      check("s4_count", 32'(digit_count), 32'd4);

      // Multiple keys
      p0 = pulses;
`ifndef MULTI_KEY_REJECT_EN
      exp_q.push_back(4'd9);
`endif
      keypad = 10'b10_0010_0001;
      step(10);
      keypad = '0;
      step(10);
`ifdef MULTI_KEY_REJECT_EN
      check("s5_pulses", 32'(pulses - p0), 32'd0);
      check("s5_D", 32'(D), 32'h5);
      check("s5_digits", 32'(digits), 32'h2345);
`else
      check("s5_pulses", 32'(pulses - p0), 32'd1);
      check("s5_D", 32'(D), 32'h9);
      check("s5_digits", 32'(digits), 32'h3459);
`endif

      // Disable mid-debounce
      p0 = pulses;
      keypad = '0; keypad[3] = 1'b1;
      step(2);
      enable_n = 1'b1;
      step(5);
      keypad = '0;
      step(2);
      enable_n = 1'b0;
      step(5);
      check("s6_abort_pulses", 32'(pulses - p0), 32'd0);
      check("s6_abort_count", 32'(digit_count), 32'd4);

      // Enable with key 6 already held, then key 8
      exp_q.push_back(4'd6);
      keypad = '0; keypad[6] = 1'b1;
      enable_n = 1'b1;
      step(3);
      enable_n = 1'b0;
      start = cyc;
      step(10);
      check("s6_enable_latency", 32'(last_pulse_cyc - (start + 1)), 32'd2);
      keypad = '0;
      step(10);
      exp_q.push_back(4'd8);
      press(8, 10, 10);
`ifdef MULTI_KEY_REJECT_EN
      check("s6_digits", 32'(digits), 32'h4568);
`else
      check("s6_digits", 32'(digits), 32'h5968);
`endif

      // Reset mid-press
      keypad = '0; keypad[1] = 1'b1;
      step(2);
      rise_q.delete();
      reset = 1'b1;
      step(2);
      keypad = '0;
      reset  = 1'b0;
      step(1);
      check("s7_D", 32'(D), 32'h0);
      check("s7_digits", 32'(digits), 32'h0);
      check("s7_count", 32'(digit_count), 32'h0);
      check("s7_load_n", 32'(load_n), 32'h1);
      step(59);
      check("s7_rise", (rise_q.size() > 0) ? 32'(rise_q[0]) : 32'hffff_ffff, 32'd50);
      check("end_exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
